// File: rtl/osc_capture.sv
// osc_capture: multi-channel trigger and capture engine with pre-trigger history and a held frame.
// Define OSC_CAP_PEAK_EN to enable per-channel peak-to-peak measurement on vpp (tied to 0 otherwise).
module osc_capture #(
    parameter int DW      = 8,
    parameter int NCH     = 2,
    parameter int DEPTH   = 1024,
    parameter int AUTO_TO = 4096,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TW     = $clog2(AUTO_TO + 1)
) (
    input  logic              clk100,
    input  logic              clr_n,
    input  logic              smp_en,
    input  logic [NCH*DW-1:0] smp_data,
    input  logic [CW-1:0]     trig_src,
    input  logic [DW-1:0]     trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic [AW-1:0]     pre_len,
    input  logic              arm,
    input  logic              disp_ack,
    input  logic [CW-1:0]     rd_ch,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic [2:0]        state,
    output logic              frame_valid,
    output logic              auto_trig,
    output logic [NCH*DW-1:0] vpp
);

    // Handshakes: smp_en qualifies smp_data for one cycle with no backpressure; frame_valid stays
    // high while a frame is held, and disp_ack releases it (disp_ack is ignored while frame_valid is low).

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_nx;
    logic [AW-1:0]   wp_q, cnt_q, pre_q, trig_addr_q;
    logic [AW-1:0]   cnt_inc, post_len, frame_start, rd_phys;
    logic [DW-1:0]   prev_q, cur;
    logic            prev_v_q;
    logic [TW-1:0]   to_q, to_inc;
    logic [CW-1:0]   tsel, rsel;
    logic            mode_single, mode_auto, nat_hit;
    logic            wr_en, fill_go, arm_go, trig_go, forced;

    logic [DW-1:0]   mem [NCH][DEPTH];

    assign mode_single = (trig_mode == 2'b10);
    assign mode_auto   = (trig_mode == 2'b00);
    assign cnt_inc     = cnt_q + 1'b1;
    assign to_inc      = to_q + 1'b1;
    // post_len = DEPTH-1-pre_len, which in AW bits is the bitwise complement.
    assign post_len    = ~pre_q;

    assign tsel = (int'(trig_src) < NCH) ? trig_src : '0;
    assign rsel = (int'(rd_ch) < NCH) ? rd_ch : '0;

    always_comb begin
        cur = '0;
        for (int c = 0; c < NCH; c++) begin
            if (tsel == CW'(c)) cur = smp_data[c*DW +: DW];
        end
    end

    always_comb begin
        nat_hit = 1'b0;
        if (prev_v_q) begin
            if (trig_slope) nat_hit = (prev_q > trig_level) && (cur <= trig_level);
            else            nat_hit = (prev_q < trig_level) && (cur >= trig_level);
        end
    end

    always_ff @(posedge clk100 or negedge clr_n) begin
        if (!clr_n) state_q <= S_IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        wr_en    = 1'b0;
        fill_go  = 1'b0;
        arm_go   = 1'b0;
        trig_go  = 1'b0;
        forced   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!mode_single || arm) begin
                    state_nx = S_FILL;
                    fill_go  = 1'b1;
                end
            end
            S_FILL: begin
                wr_en = smp_en;
                if ((pre_q == '0) || (smp_en && (cnt_inc == pre_q))) begin
                    state_nx = S_ARMED;
                    arm_go   = 1'b1;
                end
            end
            S_ARMED: begin
                wr_en  = smp_en;
                forced = smp_en && mode_auto && (to_inc >= TW'(AUTO_TO));
                if (smp_en && (nat_hit || forced)) begin
                    trig_go  = 1'b1;
                    state_nx = (post_len == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                wr_en = smp_en;
                if (smp_en && (cnt_inc == post_len)) state_nx = S_DONE;
            end
            S_DONE: begin
                if (disp_ack) begin
                    if (mode_single) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_FILL;
                        fill_go  = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge clr_n) begin
        if (!clr_n) begin
            wp_q        <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            trig_addr_q <= '0;
            prev_q      <= '0;
            prev_v_q    <= 1'b0;
            to_q        <= '0;
            auto_trig   <= 1'b0;
        end else begin
            if (wr_en) begin
                wp_q     <= wp_q + 1'b1;
                prev_q   <= cur;
                prev_v_q <= 1'b1;
            end
            if (fill_go) begin
                pre_q    <= (pre_len >= AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : pre_len;
                prev_v_q <= 1'b0;
            end
            if (fill_go || arm_go || trig_go) cnt_q <= '0;
            else if (wr_en)                   cnt_q <= cnt_inc;
            // Timeout only advances in auto mode; the mode is sampled live.
            if (arm_go)                                          to_q <= '0;
            else if ((state_q == S_ARMED) && smp_en && mode_auto) to_q <= to_inc;
            if (trig_go) begin
                trig_addr_q <= wp_q;
                auto_trig   <= !nat_hit;
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (wr_en) begin
            for (int c = 0; c < NCH; c++) mem[c][wp_q] <= smp_data[c*DW +: DW];
        end
    end

    assign frame_start = trig_addr_q - pre_q;
    assign rd_phys     = frame_start + rd_addr;

    always_ff @(posedge clk100 or negedge clr_n) begin
        if (!clr_n) rd_data <= '0;
        else        rd_data <= mem[rsel][rd_phys];
    end

    assign state       = state_q;
    assign frame_valid = (state_q == S_DONE);

`ifdef OSC_CAP_PEAK_EN
    logic [NCH*DW-1:0] min_q, max_q, min_nx, max_nx;

    always_comb begin
        min_nx = min_q;
        max_nx = max_q;
        if (wr_en) begin
            for (int c = 0; c < NCH; c++) begin
                if (smp_data[c*DW +: DW] < min_q[c*DW +: DW]) min_nx[c*DW +: DW] = smp_data[c*DW +: DW];
                if (smp_data[c*DW +: DW] > max_q[c*DW +: DW]) max_nx[c*DW +: DW] = smp_data[c*DW +: DW];
            end
        end
    end

    // The sample written on the DONE transition is folded in through min_nx/max_nx.
    always_ff @(posedge clk100 or negedge clr_n) begin
        if (!clr_n) begin
            min_q <= '1;
            max_q <= '0;
            vpp   <= '0;
        end else begin
            if (fill_go) begin
                min_q <= '1;
                max_q <= '0;
            end else begin
                min_q <= min_nx;
                max_q <= max_nx;
            end
            if ((state_nx == S_DONE) && (state_q != S_DONE)) begin
                for (int c = 0; c < NCH; c++)
                    vpp[c*DW +: DW] <= max_nx[c*DW +: DW] - min_nx[c*DW +: DW];
            end
        end
    end
`else
    assign vpp = '0;
`endif

endmodule

// File: tb/tb_osc_capture.sv
// tb_osc_capture: directed capture scenarios for osc_capture (DEPTH=16, NCH=2, DW=8, AUTO_TO=32).
// Read-port results are checked by a scoreboard queue; control outputs are checked inline.
`timescale 1ns/1ps
module tb_osc_capture;
    localparam int DW = 8, NCH = 2, DEPTH = 16, AUTO_TO = 32, AW = 4, CW = 1;
    localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_ARMED = 3'd2, S_POST = 3'd3, S_DONE = 3'd4;

    logic              clk100 = 1'b0;
    logic              clr_n = 1'b0;
    logic              smp_en = 1'b0;
    logic [NCH*DW-1:0] smp_data = '0;
    logic [CW-1:0]     trig_src = '0;
    logic [DW-1:0]     trig_level = '0;
    logic              trig_slope = 1'b0;
    logic [1:0]        trig_mode = 2'b01;
    logic [AW-1:0]     pre_len = '0;
    logic              arm = 1'b0;
    logic              disp_ack = 1'b0;
    logic [CW-1:0]     rd_ch = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DW-1:0]     rd_data;
    logic [2:0]        state;
    logic              frame_valid, auto_trig;
    logic [NCH*DW-1:0] vpp;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    string         nm_q[$];
    logic          rd_req = 1'b0;
    logic          rd_pend = 1'b0;

    // clock / reset
    always #5 clk100 = ~clk100;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    osc_capture #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .AUTO_TO(AUTO_TO)) dut (
        .clk100(clk100), .clr_n(clr_n), .smp_en(smp_en), .smp_data(smp_data),
        .trig_src(trig_src), .trig_level(trig_level), .trig_slope(trig_slope),
        .trig_mode(trig_mode), .pre_len(pre_len), .arm(arm), .disp_ack(disp_ack),
        .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data), .state(state),
        .frame_valid(frame_valid), .auto_trig(auto_trig), .vpp(vpp)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: a read issued in one cycle is compared after the next rising edge
    always @(posedge clk100) rd_pend <= rd_req;

    always @(negedge clk100) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                logic [DW-1:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                chk(nm, 32'(rd_data), 32'(e));
            end
        end
    end

    // driver tasks (all called aligned to a falling edge)
    task automatic send(input logic [7:0] c0, input logic [7:0] c1);
        smp_en   = 1'b1;
        smp_data = {c1, c0};
        @(negedge clk100);
        smp_en   = 1'b0;
    endtask

    task automatic rd(input logic [CW-1:0] ch, input logic [AW-1:0] a, input logic [7:0] e, input string nm);
        rd_ch   = ch;
        rd_addr = a;
        rd_req  = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk100);
        rd_req  = 1'b0;
    endtask

    task automatic pulse_ack();
        disp_ack = 1'b1;
        @(negedge clk100);
        disp_ack = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
        int k = 0;
        while (state !== s && k < lim) begin
            @(negedge clk100);
            k++;
        end
        chk(nm, 32'(state), 32'(s));
    endtask

    // ramp on ch0 starting at v0, ch1 alternating 0x20/0xE0; stops at DONE
    task automatic ramp(input logic [7:0] v0, input logic [7:0] trig_v, input string nm, output logic [7:0] last_v);
        logic [7:0] v = v0;
        int k = 0;
        last_v = '0;
        while (state !== S_DONE && k < 300) begin
            send(v, v[0] ? 8'hE0 : 8'h20);
            if (v == trig_v) chk({nm, "_post"}, 32'(state), 32'(S_POST));
            last_v = v;
            v++;
            k++;
        end
        chk({nm, "_done"}, 32'(state), 32'(S_DONE));
    endtask

    initial begin
        logic [7:0] last_v;
        logic [7:0] v;
        int k;
        int post_at;

        // reset state
        trig_mode  = 2'b01;
        trig_level = 8'h80;
        trig_slope = 1'b0;
        pre_len    = 4'd4;
        repeat (3) @(negedge clk100);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_auto", 32'(auto_trig), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        chk("rst_vpp", 32'(vpp), 32'd0);
        clr_n = 1'b1;

        // 1: normal, rising, level 0x80, pre_len 4
        wait_state(S_FILL, 5, "s1_fill");
        ramp(8'h00, 8'h80, "s1", last_v);
        chk("s1_last", 32'(last_v), 32'h8B);
        chk("s1_fv", 32'(frame_valid), 32'd1);
        chk("s1_auto", 32'(auto_trig), 32'd0);
`ifdef OSC_CAP_PEAK_EN
        chk("s1_vpp", 32'(vpp), 32'hC08B);
`else
        chk("s1_vpp", 32'(vpp), 32'h0000);
`endif
        repeat (3) send(8'hFF, 8'hFF);
        chk("s1_hold", 32'(state), 32'(S_DONE));
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'(8'h7C + i);
            rd(1'b0, AW'(i), v, $sformatf("s1_rd0_%0d", i));
            rd(1'b1, AW'(i), v[0] ? 8'hE0 : 8'h20, $sformatf("s1_rd1_%0d", i));
        end
        rd(1'b0, 4'd4, 8'h80, "s1_rd_trig");
        trig_mode = 2'b00;
        pulse_ack();
        chk("s1_ack_fv", 32'(frame_valid), 32'd0);
        chk("s1_ack_state", 32'(state), 32'(S_FILL));

        // 2: auto mode, constant 0x10 below level, forced on 32nd ARMED sample
        k = 0;
        post_at = -1;
        while (state !== S_DONE && k < 100) begin
            send(8'h10, 8'h33);
            k++;
            if (state === S_POST && post_at < 0) post_at = k;
        end
        chk("s2_post_at", 32'(post_at), 32'd36);
        chk("s2_done_at", 32'(k), 32'd47);
        chk("s2_auto", 32'(auto_trig), 32'd1);
        chk("s2_vpp", 32'(vpp), 32'd0);
        for (int i = 0; i < DEPTH; i++) rd(1'b0, AW'(i), 8'h10, $sformatf("s2_rd%0d", i));
        rd(1'b1, 4'd9, 8'h33, "s2_rd_ch1");
        trig_mode = 2'b10;
        pulse_ack();
        chk("s2_ack_state", 32'(state), 32'(S_IDLE));

        // 3: single, falling, level 0x40, pre_len 2; nothing written before arm
        trig_slope = 1'b1;
        trig_level = 8'h40;
        pre_len    = 4'd2;
        repeat (3) send(8'h99, 8'h99);
        chk("s3_idle", 32'(state), 32'(S_IDLE));
        rd(1'b0, 4'd0, 8'h10, "s3_nowr0");
        rd(1'b0, 4'd15, 8'h10, "s3_nowr15");
        arm = 1'b1;
        @(negedge clk100);
        arm = 1'b0;
        chk("s3_arm", 32'(state), 32'(S_FILL));
        k = 0;
        while (state !== S_DONE && k < 40) begin
            v = (k < 6) ? 8'(8'h90 - 16 * k) : 8'(8'h40 - (k - 5));
            send(v, 8'h77);
            if (k == 1) chk("s3_armed", 32'(state), 32'(S_ARMED));
            if (k == 5) chk("s3_post", 32'(state), 32'(S_POST));
            k++;
        end
        chk("s3_done_at", 32'(k), 32'd19);
        chk("s3_auto", 32'(auto_trig), 32'd0);
        rd(1'b0, 4'd0, 8'h60, "s3_rd0");
        rd(1'b0, 4'd1, 8'h50, "s3_rd1");
        rd(1'b0, 4'd2, 8'h40, "s3_rd2");
        rd(1'b0, 4'd3, 8'h3F, "s3_rd3");
        rd(1'b0, 4'd15, 8'h33, "s3_rd15");
        pulse_ack();
        chk("s3_ack_idle", 32'(state), 32'(S_IDLE));
        repeat (4) send(8'h01, 8'h01);
        chk("s3_need_arm", 32'(state), 32'(S_IDLE));

        // 4: pre_len 15, rising trigger on 0x55 goes straight to DONE
        trig_slope = 1'b0;
        trig_level = 8'h55;
        pre_len    = 4'd15;
        arm = 1'b1;
        @(negedge clk100);
        arm = 1'b0;
        chk("s4_arm", 32'(state), 32'(S_FILL));
        for (int i = 0; i < 14; i++) send(8'h10, 8'h44);
        chk("s4_fill14", 32'(state), 32'(S_FILL));
        send(8'h10, 8'h44);
        chk("s4_armed", 32'(state), 32'(S_ARMED));
        send(8'h20, 8'h44);
        chk("s4_armed2", 32'(state), 32'(S_ARMED));
        send(8'h55, 8'h44);
        chk("s4_done", 32'(state), 32'(S_DONE));
        chk("s4_fv", 32'(frame_valid), 32'd1);
        rd(1'b0, 4'd15, 8'h55, "s4_rd15");
        rd(1'b0, 4'd14, 8'h20, "s4_rd14");
        rd(1'b0, 4'd0, 8'h10, "s4_rd0");
        rd(1'b1, 4'd7, 8'h44, "s4_rd_ch1");
        pulse_ack();
        chk("s4_ack_idle", 32'(state), 32'(S_IDLE));

        // 5: reset asserted in POST, then a clean restart
        trig_mode  = 2'b01;
        trig_level = 8'h80;
        pre_len    = 4'd4;
        wait_state(S_FILL, 5, "s5_fill");
        for (int i = 0; i < 19; i++) send(8'(8'h70 + i), 8'h20);
        chk("s5_in_post", 32'(state), 32'(S_POST));
        clr_n = 1'b0;
        #1;
        chk("s5_rst_state", 32'(state), 32'(S_IDLE));
        chk("s5_rst_fv", 32'(frame_valid), 32'd0);
        chk("s5_rst_rd", 32'(rd_data), 32'd0);
        chk("s5_rst_vpp", 32'(vpp), 32'd0);
        @(negedge clk100);
        clr_n = 1'b1;
        wait_state(S_FILL, 5, "s5_refill");
        ramp(8'h00, 8'h80, "s5b", last_v);
        chk("s5b_last", 32'(last_v), 32'h8B);
        chk("s5b_auto", 32'(auto_trig), 32'd0);
        rd(1'b0, 4'd0, 8'h7C, "s5b_rd0");
        rd(1'b0, 4'd4, 8'h80, "s5b_rd4");
        rd(1'b0, 4'd15, 8'h8B, "s5b_rd15");

        // final report
        repeat (3) @(negedge clk100);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
